// File: rtl/wr_line_ram_pkg.sv
// Shared width constants for the video write-path line buffer RAM.
package wr_line_ram_pkg;

  localparam int WR_DATA_WIDTH  = 32;
  localparam int WR_ADDR_WIDTH  = 12;
  localparam int RD_DATA_WIDTH  = 256;
  localparam int RD_ADDR_WIDTH  = 9;
  localparam int LANES          = RD_DATA_WIDTH / WR_DATA_WIDTH;
  localparam int LANE_SEL_WIDTH = WR_ADDR_WIDTH - RD_ADDR_WIDTH;

endpackage : wr_line_ram_pkg

// File: rtl/wr_line_ram_bank.sv
// One 32-bit lane of the line buffer: simple dual-port RAM with a
// registered read-first output that clears asynchronously on reset.
module wr_line_ram_bank
  import wr_line_ram_pkg::*;
#(
  parameter int DATA_WIDTH = WR_DATA_WIDTH,
  parameter int ADDR_WIDTH = RD_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; gating the write
  // with rstn keeps writes out while reset is held without touching contents.
  always_ff @(posedge clk) begin
    if (we && rstn) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking update means a same-cycle write is not seen: read-first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule : wr_line_ram_bank

// File: rtl/wr_line_ram.sv
// Asymmetric line buffer: 32-bit word writes, 256-bit beat reads, one clock.
// Each lane of a beat lives in its own bank, selected by the low write address bits.
module wr_line_ram #(
  parameter int WR_DATA_WIDTH = wr_line_ram_pkg::WR_DATA_WIDTH,
  parameter int WR_ADDR_WIDTH = wr_line_ram_pkg::WR_ADDR_WIDTH,
  parameter int RD_DATA_WIDTH = wr_line_ram_pkg::RD_DATA_WIDTH,
  parameter int RD_ADDR_WIDTH = wr_line_ram_pkg::RD_ADDR_WIDTH
) (
  input  logic                     ddr_clk,
  input  logic                     ddr_rstn,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic                     wr_en,
  input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_DATA_WIDTH-1:0] rd_data
);

  localparam int LANES          = RD_DATA_WIDTH / WR_DATA_WIDTH;
  localparam int LANE_SEL_WIDTH = WR_ADDR_WIDTH - RD_ADDR_WIDTH;

  logic [LANE_SEL_WIDTH-1:0] wr_lane;
  logic [RD_ADDR_WIDTH-1:0]  wr_beat;

  assign wr_lane = wr_addr[LANE_SEL_WIDTH-1:0];
  assign wr_beat = wr_addr[WR_ADDR_WIDTH-1:LANE_SEL_WIDTH];

  for (genvar k = 0; k < LANES; k++) begin : g_bank
    logic bank_we;

    assign bank_we = wr_en && (wr_lane == LANE_SEL_WIDTH'(k));

    // Lane k drives rd_data[32k+31:32k], so lane 0 lands in the LSBs.
    wr_line_ram_bank #(
      .DATA_WIDTH (WR_DATA_WIDTH),
      .ADDR_WIDTH (RD_ADDR_WIDTH)
    ) u_bank (
      .clk   (ddr_clk),
      .rstn  (ddr_rstn),
      .we    (bank_we),
      .waddr (wr_beat),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (rd_data[k*WR_DATA_WIDTH +: WR_DATA_WIDTH])
    );
  end

endmodule : wr_line_ram

// File: tb/tb_wr_line_ram.sv
// Directed self-checking bench for wr_line_ram: reset, lane packing,
// partial beats, a full packed video line, read-during-write and wrap.
module tb_wr_line_ram;

  logic         ddr_clk = 1'b0;
  logic         ddr_rstn;
  logic [31:0]  wr_data;
  logic [11:0]  wr_addr;
  logic         wr_en;
  logic [8:0]   rd_addr;
  logic [255:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [4096];

  wr_line_ram dut (
    .ddr_clk  (ddr_clk),
    .ddr_rstn (ddr_rstn),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .wr_en    (wr_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 ddr_clk = ~ddr_clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; the write lands on the next rising edge.
  task automatic write_word(input logic [11:0] addr, input logic [31:0] data, input logic en);
    wr_addr = addr;
    wr_data = data;
    wr_en   = en;
    @(negedge ddr_clk);
    wr_en   = 1'b0;
    if (en) model[addr] = data;
  endtask

  function automatic logic [255:0] model_beat(input int beat);
    logic [255:0] b;
    for (int l = 0; l < 8; l++) b[32*l +: 32] = model[beat*8 + l];
    return b;
  endfunction

  // 24-bit test pixel; the line is a little-endian byte stream of pixels.
  function automatic logic [23:0] pixel(input int i);
    return 24'(i * 24'h010203) ^ 24'h5A3C96;
  endfunction

  function automatic logic [7:0] line_byte(input int j);
    logic [23:0] p;
    p = pixel(j / 3);
    return p[8*(j%3) +: 8];
  endfunction

  initial begin
    logic [255:0] exp;
    ddr_rstn = 1'b0;
    wr_data  = '0;
    wr_addr  = '0;
    wr_en    = 1'b0;
    rd_addr  = '0;

    repeat (3) @(negedge ddr_clk);
    check("reset_rd_data", rd_data, '0);
    ddr_rstn = 1'b1;
    @(negedge ddr_clk);

    // Give every word a defined value before any beat is read.
    for (int a = 0; a < 4096; a++) write_word(12'(a), 32'h0, 1'b1);

    // Lane packing
    for (int i = 0; i < 8; i++) write_word(12'(i), 32'h11111111 * (i + 1), 1'b1);
    rd_addr = 9'd0;
    @(negedge ddr_clk);
    check("lane_pack", rd_data,
          256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);

    // Partial beat: only lane 5 of beat 1 changes
    for (int i = 0; i < 8; i++) write_word(12'(8 + i), 32'h0B0B0000 | 32'(i), 1'b1);
    write_word(12'h00D, 32'hDEADBEEF, 1'b1);
    rd_addr = 9'd1;
    @(negedge ddr_clk);
    check("partial_lane5", 256'(rd_data[191:160]), 256'(32'hDEADBEEF));
    check("partial_beat", rd_data,
          256'h0B0B0007_0B0B0006_DEADBEEF_0B0B0004_0B0B0003_0B0B0002_0B0B0001_0B0B0000);

    // Read-during-write to beat 5: old data first, new data one read later
    wr_addr = 12'd40;
    wr_data = 32'hCAFEF00D;
    wr_en   = 1'b1;
    rd_addr = 9'd5;
    @(negedge ddr_clk);
    wr_en = 1'b0;
    model[40] = 32'hCAFEF00D;
    check("rdw_old_lane0", 256'(rd_data[31:0]), 256'(32'h0));
    @(negedge ddr_clk);
    check("rdw_new_lane0", 256'(rd_data[31:0]), 256'(32'hCAFEF00D));
    @(negedge ddr_clk);
    check("rdw_hold_beat", rd_data, 256'(32'hCAFEF00D));

    // Wrap to the top addresses, then a disabled write
    write_word(12'd4095, 32'hA5A5A5A5, 1'b1);
    rd_addr = 9'd511;
    @(negedge ddr_clk);
    check("wrap_lane7", 256'(rd_data[255:224]), 256'(32'hA5A5A5A5));
    check("wrap_beat", rd_data, {32'hA5A5A5A5, 224'h0});
    write_word(12'd4095, 32'h12345678, 1'b0);
    write_word(12'd4088, 32'h87654321, 1'b0);
    @(negedge ddr_clk);
    check("wr_en_low", rd_data, {32'hA5A5A5A5, 224'h0});

    // Full line: 1280 x 24-bit pixels packed into 960 words
    for (int w = 0; w < 960; w++)
      write_word(12'(w), {line_byte(4*w+3), line_byte(4*w+2), line_byte(4*w+1), line_byte(4*w)}, 1'b1);
    exp = '0;
    for (int l = 0; l < 8; l++)
      exp[32*l +: 32] = {line_byte(4*l+3), line_byte(4*l+2), line_byte(4*l+1), line_byte(4*l)};
    exp[23:0] = 24'h5A3C96;
    for (int b = 0; b < 120; b++) begin
      rd_addr = 9'(b);
      @(negedge ddr_clk);
      check($sformatf("line_beat_%0d", b), rd_data, model_beat(b));
    end
    rd_addr = 9'd0;
    @(negedge ddr_clk);
    check("line_beat0_pixel0", 256'(rd_data[23:0]), 256'(exp[23:0]));

    // Mid-cycle reset clears the output immediately and blocks writes
    @(posedge ddr_clk);
    #2;
    ddr_rstn = 1'b0;
    wr_addr  = 12'd0;
    wr_data  = 32'hFFFFFFFF;
    wr_en    = 1'b1;
    #1;
    check("async_reset_clear", rd_data, '0);
    @(negedge ddr_clk);
    check("reset_hold_1", rd_data, '0);
    @(negedge ddr_clk);
    check("reset_hold_2", rd_data, '0);
    wr_en    = 1'b0;
    ddr_rstn = 1'b1;
    rd_addr  = 9'd0;
    @(negedge ddr_clk);
    check("post_reset_read", rd_data, model_beat(0));
    check("post_reset_no_write", 256'(rd_data[31:0]), 256'(exp[31:0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wr_line_ram
